// File: rtl/dw_ram_rw_s_be_zinit_if.sv
// Purpose: request/response bundle for the self-initialising single-port RAM.
// Latency: none (signal container only).
// Backpressure: none; the slave reports busy and silently drops requests while set.
interface dw_ram_rw_s_be_zinit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                      clr;
    logic                      cs_n;
    logic                      wr_n;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [ADDR_WIDTH-1:0]     rw_addr;
    logic [DATA_WIDTH-1:0]     data_in;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      rd_valid;
    logic                      busy;

    modport master (
        output clr, cs_n, wr_n, be, rw_addr, data_in,
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  clr, cs_n, wr_n, be, rw_addr, data_in,
        output data_out, rd_valid, busy
    );
endinterface

// File: rtl/dw_ram_rw_s_be_zinit.sv
// Purpose: single-port RAM with byte-enable writes and a hardware fill-to-INIT_VAL sequencer.
// Latency: read data 1 cycle (RD_PIPE=0) or 2 cycles (RD_PIPE=1), throughput one read per cycle.
// Backpressure: none; while busy (init running) or clr is high, requests are dropped.
module dw_ram_rw_s_be_zinit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    RD_PIPE    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    dw_ram_rw_s_be_zinit_if.slave  s_if
);

    localparam int                  LP_NBYTES = DATA_WIDTH / 8;
    // DEPTH widened by one bit so the range check also works when DEPTH == 2**ADDR_WIDTH
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_init_ptr;
    logic [ADDR_WIDTH-1:0]   w_init_ptr_nxt;

    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                    w_busy;
    logic                    w_user_ok;
    logic                    w_in_range;
    logic                    w_wr_req;
    logic                    w_rd_req;

    logic                    r_rd_vld1;
    logic [DATA_WIDTH-1:0]   r_rd_dat1;
    logic                    w_rd_vld_out;
    logic [DATA_WIDTH-1:0]   w_rd_dat_out;

    // State and fill pointer register; reset restarts the fill from word 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_ptr <= w_init_ptr_nxt;
        end
    end

    // Next state, fill pointer and request qualification; clr wins over everything
    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        w_busy         = 1'b0;
        w_user_ok      = 1'b0;
        if (s_if.clr) begin
            w_state_nxt    = ST_INIT;
            w_init_ptr_nxt = '0;
        end else if (r_state == ST_INIT) begin
            if (r_init_ptr == LP_LAST) begin
                w_state_nxt    = ST_IDLE;
                w_init_ptr_nxt = '0;
            end else begin
                w_init_ptr_nxt = r_init_ptr + 1'b1;
            end
        end
        case (r_state)
            ST_INIT: w_busy    = 1'b1;
            ST_IDLE: w_user_ok = !s_if.clr;
            default: w_busy    = 1'b1;
        endcase
    end

    assign w_in_range = ({1'b0, s_if.rw_addr} < LP_DEPTH);
    assign w_wr_req   = w_user_ok && !s_if.cs_n && !s_if.wr_n && w_in_range;
    // Out-of-range reads still produce a (zero) response
    assign w_rd_req   = w_user_ok && !s_if.cs_n &&  s_if.wr_n;

    // Array write port: fill word during init, byte-masked user write in idle
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_ptr] <= INIT_VAL;
        end else if (w_wr_req) begin
            for (int i = 0; i < LP_NBYTES; i++) begin
                if (s_if.be[i]) begin
                    r_mem[s_if.rw_addr][8*i +: 8] <= s_if.data_in[8*i +: 8];
                end
            end
        end
    end

    // First read stage: registered array output, held between reads
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_vld1 <= 1'b0;
            r_rd_dat1 <= '0;
        end else begin
            r_rd_vld1 <= w_rd_req;
            if (w_rd_req) begin
                r_rd_dat1 <= w_in_range ? r_mem[s_if.rw_addr] : '0;
            end
        end
    end

    generate
        if (RD_PIPE == 0) begin : g_pipe0
            assign w_rd_vld_out = r_rd_vld1;
            assign w_rd_dat_out = r_rd_dat1;
        end else begin : g_pipe1
            logic                  r_rd_vld2;
            logic [DATA_WIDTH-1:0] r_rd_dat2;

            // Optional output stage; only loads when stage one carries a result
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rd_vld2 <= 1'b0;
                    r_rd_dat2 <= '0;
                end else begin
                    r_rd_vld2 <= r_rd_vld1;
                    if (r_rd_vld1) begin
                        r_rd_dat2 <= r_rd_dat1;
                    end
                end
            end

            assign w_rd_vld_out = r_rd_vld2;
            assign w_rd_dat_out = r_rd_dat2;
        end
    endgenerate

    assign s_if.data_out = w_rd_dat_out;
    assign s_if.rd_valid = w_rd_vld_out;
    assign s_if.busy     = w_busy;

endmodule

// File: tb/tb_dw_ram_rw_s_be_zinit.sv
// Purpose: scoreboard bench driving two RAM configurations with identical stimulus.
// Latency: checks exact response cycle per configuration (1 and 2 cycles).
// Backpressure: models busy/clr request dropping in the reference.
module tb_dw_ram_rw_s_be_zinit;

    logic clk;
    logic rst_n;

    // Configuration 0: DEPTH 64, RD_PIPE 0, INIT A5A5A5A5; configuration 1: DEPTH 48, RD_PIPE 1, INIT 0
    dw_ram_rw_s_be_zinit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) if0 ();
    dw_ram_rw_s_be_zinit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) if1 ();

    assign if1.clr     = if0.clr;
    assign if1.cs_n    = if0.cs_n;
    assign if1.wr_n    = if0.wr_n;
    assign if1.be      = if0.be;
    assign if1.rw_addr = if0.rw_addr;
    assign if1.data_in = if0.data_in;

    dw_ram_rw_s_be_zinit #(
        .DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(6), .RD_PIPE(0), .INIT_VAL(32'hA5A5A5A5)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(if0.slave)
    );

    dw_ram_rw_s_be_zinit #(
        .DATA_WIDTH(32), .DEPTH(48), .ADDR_WIDTH(6), .RD_PIPE(1), .INIT_VAL(32'h0)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] m0 [64];
    logic [31:0] m1 [64];
    int          rem [2];
    logic [31:0] last [2];
    exp_t        q0 [$];
    exp_t        q1 [$];

    function automatic int depth_of(input int d);
        return (d == 0) ? 64 : 48;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] init_of(input int d);
        return (d == 0) ? 32'hA5A5A5A5 : 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, req);
        end
    endtask

    // ---------------- reference model: a plain array per configuration ----------------
    function automatic logic [31:0] mrd(input int d, input int a);
        return (d == 0) ? m0[a] : m1[a];
    endfunction

    task automatic mwr(input int d, input int a, input logic [31:0] v);
        if (d == 0) m0[a] = v; else m1[a] = v;
    endtask

    task automatic fill(input int d);
        for (int i = 0; i < 64; i++) mwr(d, i, init_of(d));
    endtask

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpop(input int d, output exp_t e);
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    endtask

    task automatic qpeek(input int d, output exp_t e);
        if (d == 0) e = q0[0]; else e = q1[0];
    endtask

    // Model advances on every rising edge using the request presented in that cycle
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                rem[d]  = depth_of(d);
                last[d] = 32'h0;
                fill(d);
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                int          a;
                logic [31:0] w;
                exp_t        e;
                a = int'(if0.rw_addr);
                if (rem[d] == 0 && !if0.clr && !if0.cs_n) begin
                    if (!if0.wr_n) begin
                        if (a < depth_of(d)) begin
                            w = mrd(d, a);
                            for (int b = 0; b < 4; b++)
                                if (if0.be[b]) w[8*b +: 8] = if0.data_in[8*b +: 8];
                            mwr(d, a, w);
                        end
                    end else begin
                        e.cyc = cyc + lat_of(d) - 1;
                        e.dat = (a < depth_of(d)) ? mrd(d, a) : 32'h0;
                        qpush(d, e);
                    end
                end
                if (if0.clr) begin
                    rem[d] = depth_of(d);
                    fill(d);
                end else if (rem[d] > 0) begin
                    rem[d] = rem[d] - 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic mon(input int d, input logic vld, input logic [31:0] dat, input logic bsy);
        exp_t e;
        chk($sformatf("busy%0d", d), {31'b0, bsy}, {31'b0, rem[d] != 0});
        if (vld) begin
            if (qsize(d) == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_valid%0d at cycle %0d: got unexpected pulse data %h expected none", d, cyc, dat);
            end else begin
                qpop(d, e);
                chk($sformatf("rd_cycle%0d", d), cyc, e.cyc);
                chk($sformatf("rd_data%0d", d), dat, e.dat);
                last[d] = e.dat;
            end
        end else begin
            chk($sformatf("hold%0d", d), dat, last[d]);
            if (qsize(d) != 0) begin
                qpeek(d, e);
                if (e.cyc <= cyc) begin
                    qpop(d, e);
                    chk($sformatf("rd_missing%0d", d), 32'h0, 32'h1);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_data0",  if0.data_out, 32'h0);
            chk("rst_vld0",   {31'b0, if0.rd_valid}, 32'h0);
            chk("rst_busy0",  {31'b0, if0.busy}, 32'h1);
            chk("rst_data1",  if1.data_out, 32'h0);
            chk("rst_vld1",   {31'b0, if1.rd_valid}, 32'h0);
            chk("rst_busy1",  {31'b0, if1.busy}, 32'h1);
        end else begin
            mon(0, if0.rd_valid, if0.data_out, if0.busy);
            mon(1, if1.rd_valid, if1.data_out, if1.busy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input logic c_n, input logic w_n, input logic [3:0] b,
                       input logic [5:0] a, input logic [31:0] dat, input logic cl);
        @(posedge clk);
        #1;
        if0.cs_n    = c_n;
        if0.wr_n    = w_n;
        if0.be      = b;
        if0.rw_addr = a;
        if0.data_in = dat;
        if0.clr     = cl;
    endtask

    task automatic idle();
        req(1'b1, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] dat, input logic [3:0] b);
        req(1'b0, 1'b0, b, a, dat, 1'b0);
    endtask

    task automatic rd(input logic [5:0] a);
        req(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b0);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            idle();
            done = !if0.busy && !if1.busy;
        end
        if (!done) chk("wait_idle_timeout", 32'h1, 32'h0);
    endtask

    task automatic read_all();
        for (int a = 0; a < 64; a++) rd(6'(a));
        repeat (4) idle();
    endtask

    initial begin
        rst_n       = 1'b1;
        if0.cs_n    = 1'b1;
        if0.wr_n    = 1'b1;
        if0.be      = 4'h0;
        if0.rw_addr = 6'd0;
        if0.data_in = 32'h0;
        if0.clr     = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) idle();
        #0 rst_n = 1'b1;

        // Fill duration is checked every cycle by the busy comparison
        wait_idle();
        read_all();

        // Read-after-write, then a byte-masked write
        wr(6'd5, 32'h11223344, 4'hF);
        rd(6'd5);
        wr(6'd3, 32'hDEADBEEF, 4'b0101);
        rd(6'd3);
        idle();

        // Beyond DEPTH for the 48-word configuration, then neighbour word 2
        wr(6'd50, 32'hCAFEF00D, 4'hF);
        rd(6'd50);
        rd(6'd2);
        repeat (3) idle();

        // Back-to-back reads of 0..7
        for (int a = 0; a < 8; a++) rd(6'(a));
        repeat (3) idle();

        // Random traffic with occasional clr
        for (int i = 0; i < 600; i++) begin
            req(($urandom_range(3) == 0), $urandom_range(1) == 1, 4'($urandom_range(15)),
                6'($urandom_range(63)), $urandom, ($urandom_range(60) == 0));
        end
        wait_idle();
        read_all();

        // clr mid-traffic, writes during busy, second clr ten init cycles later
        wr(6'd7, 32'h01020304, 4'hF);
        rd(6'd7);
        req(1'b0, 1'b0, 4'hF, 6'd9, 32'h55555555, 1'b1);
        for (int i = 0; i < 9; i++) wr(6'(i), 32'hFFFF0000 | 32'(i), 4'hF);
        req(1'b0, 1'b0, 4'hF, 6'd1, 32'h77777777, 1'b1);
        wait_idle();
        read_all();

        // Reset while a read is in flight
        wr(6'd4, 32'h13572468, 4'hF);
        rd(6'd4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        if0.cs_n = 1'b1;
        repeat (2) idle();
        #0 rst_n = 1'b1;
        wait_idle();
        for (int a = 0; a < 8; a++) rd(6'(a));
        repeat (5) idle();

        chk("queue0_drained", q0.size(), 32'h0);
        chk("queue1_drained", q1.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
